// File: rtl/uart_csr_responder.sv
// UART peripheral: single-cycle register responder on the native bus plus an
// 8N1 transmitter and a 2-flop-synchronized, mid-bit-sampling receiver.
`timescale 1ns/1ps
module uart_csr_responder #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              txd,
  input  logic              rxd
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic              ready_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DIV_W-1:0]  div_q;
  logic              txen_q, rxen_q;

  state_e            tx_state_q;
  logic [DIV_W-1:0]  tx_cnt_q;
  logic [2:0]        tx_bit_q;
  logic [7:0]        tx_shift_q;
  logic              txd_q;

  logic              rxd_s1_q, rxd_s2_q, rxd_prev_q;
  state_e            rx_state_q;
  logic [DIV_W-1:0]  rx_cnt_q;
  logic [2:0]        rx_bit_q;
  logic [7:0]        rx_shift_q;
  logic [7:0]        rx_buf_q;
  logic              rx_ready_q;

  // Only the low bits of wdata carry meaning; the rest are folded away here.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  logic wr_en, rd_en;
  logic wr_softreset, wr_div, wr_txdata, wr_txen, wr_rxen, rd_rxdata;
  assign wr_en        = valid && (wstrb != 4'b0000);
  assign rd_en        = valid && (wstrb == 4'b0000);
  assign wr_softreset = wr_en && (addr == ADDR_W'(0)) && wdata[0];
  assign wr_div       = wr_en && (addr == ADDR_W'(1));
  assign wr_txdata    = wr_en && (addr == ADDR_W'(2));
  assign wr_txen      = wr_en && (addr == ADDR_W'(3));
  assign wr_rxen      = wr_en && (addr == ADDR_W'(4));
  assign rd_rxdata    = rd_en && (addr == ADDR_W'(7));

  logic tx_ready, tx_start;
  assign tx_ready = txen_q && (tx_state_q == S_IDLE);
  assign tx_start = wr_txdata && tx_ready;

  // Bit period P = max(DIV,1); receiver start-bit check at P/2, at least 1.
  logic [DIV_W-1:0] period, half_period;
  always_comb begin
    period      = (div_q == '0) ? DIV_W'(1) : div_q;
    half_period = period >> 1;
    if (half_period == '0) half_period = DIV_W'(1);
  end

  logic rx_fall;
  assign rx_fall = rxd_prev_q && !rxd_s2_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (addr)
        ADDR_W'(5): rdata_d = DATA_W'(tx_ready);
        ADDR_W'(6): rdata_d = DATA_W'(rx_ready_q);
        ADDR_W'(7): rdata_d = DATA_W'(rx_buf_q);
        default:    rdata_d = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // block sees pre-edge values and block order never matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      div_q   <= '0;
      txen_q  <= 1'b0;
      rxen_q  <= 1'b0;
    end else begin
      ready_q <= valid;
      if (valid) rdata_q <= rdata_d;
      if (wr_div) div_q <= wdata[DIV_W-1:0];
      if (wr_softreset) begin
        txen_q <= 1'b0;
        rxen_q <= 1'b0;
      end else begin
        if (wr_txen) txen_q <= wdata[0];
        if (wr_rxen) rxen_q <= wdata[0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else if (wr_softreset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (tx_start) begin
            tx_shift_q <= wdata[7:0];
            tx_cnt_q   <= '0;
            txd_q      <= 1'b0;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_q >= period - DIV_W'(1)) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_state_q <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + DIV_W'(1);
          end
        end
        S_DATA: begin
          if (tx_cnt_q >= period - DIV_W'(1)) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= S_STOP;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + DIV_W'(1);
          end
        end
        S_STOP: begin
          if (tx_cnt_q >= period - DIV_W'(1)) begin
            tx_cnt_q   <= '0;
            tx_state_q <= S_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + DIV_W'(1);
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  // rxd is asynchronous; sync flops idle high so release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_buf_q   <= '0;
      rx_ready_q <= 1'b0;
    end else if (wr_softreset) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      // The RXDATA read clear comes first so a same-cycle store below overrides it.
      if (rd_rxdata) rx_ready_q <= 1'b0;
      case (rx_state_q)
        S_IDLE: begin
          if (rxen_q && rx_fall) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt_q >= half_period - DIV_W'(1)) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rxd_s2_q ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + DIV_W'(1);
          end
        end
        S_DATA: begin
          if (rx_cnt_q >= period - DIV_W'(1)) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + DIV_W'(1);
          end
        end
        S_STOP: begin
          if (rx_cnt_q >= period - DIV_W'(1)) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_IDLE;
            if (rxd_s2_q && !rx_ready_q) begin
              rx_buf_q   <= rx_shift_q;
              rx_ready_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + DIV_W'(1);
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign txd   = txd_q;

endmodule

// File: tb/tb_uart_csr_responder.sv
// Scoreboarded bench for uart_csr_responder: bus tasks queue expected read
// data, a negedge monitor pops and compares on every ready pulse.
`timescale 1ns/1ps
module tb_uart_csr_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        txd;
  logic        rxd;

  always #5 clk = ~clk;

  uart_csr_responder #(.ADDR_W(3), .DATA_W(32), .DIV_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (valid),
    .addr  (addr),
    .wdata (wdata),
    .wstrb (wstrb),
    .rdata (rdata),
    .ready (ready),
    .txd   (txd),
    .rxd   (rxd)
  );

  typedef struct {
    logic        is_rd;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic v_q;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Caller is at a negedge; the access is sampled at the following posedge.
  task automatic bus(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp, input string nm);
    exp_t e;
    e.is_rd = (s == 4'b0000);
    e.exp   = exp;
    e.name  = nm;
    sb.push_back(e);
    valid = 1'b1;
    addr  = a;
    wdata = d;
    wstrb = s;
    @(negedge clk);
    valid = 1'b0;
    addr  = '0;
    wdata = '0;
    wstrb = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input string nm);
    bus(a, d, 4'hF, 32'h0, nm);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    bus(a, 32'h0, 4'h0, exp, nm);
  endtask

  // Starts at the negedge right after the TXDATA acceptance edge.
  task automatic watch_tx(input logic [7:0] b, input int p, input string nm);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10 * p; i++) begin
      check(nm, {31'b0, txd}, {31'b0, fr[i / p]});
      @(negedge clk);
    end
    check({nm, "_idle"}, {31'b0, txd}, 32'h1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int p);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = fr[k];
      repeat (p) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= 1'b0;
    else        v_q <= valid;
  end

  always @(negedge clk) begin
    if (ready || v_q) check("ready_latency", {31'b0, ready}, {31'b0, v_q});
    if (ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready with empty scoreboard at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_rd) check(mon_e.name, rdata, mon_e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    addr  = '0;
    wdata = '0;
    wstrb = '0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", {31'b0, txd}, 32'h1);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back reads after reset.
    rd(3'd5, 32'h0, "txready_rst");
    rd(3'd6, 32'h0, "rxready_rst");
    rd(3'd7, 32'h0, "rxdata_rst");
    rd(3'd1, 32'h0, "wo_read_zero");

    // Transmit 0x55 at P=4, with a busy TXDATA write that must be ignored.
    wr(3'd1, 32'd4, "div4");
    wr(3'd3, 32'd1, "txen");
    rd(3'd5, 32'h1, "txready_idle");
    wr(3'd2, 32'h55, "txdata55");
    fork
      watch_tx(8'h55, 4, "tx55");
      begin
        rd(3'd5, 32'h0, "txready_after_write");
        wr(3'd2, 32'hFF, "txdata_busy");
        repeat (15) @(negedge clk);
        rd(3'd5, 32'h0, "txready_mid");
      end
    join
    rd(3'd5, 32'h1, "txready_done");

    // Receive 0xA3 at P=8.
    wr(3'd1, 32'd8, "div8");
    wr(3'd4, 32'd1, "rxen");
    send_rx(8'hA3, 1'b1, 8);
    repeat (4) @(negedge clk);
    rd(3'd6, 32'h1, "rxready_a3");
    rd(3'd7, 32'hA3, "rxdata_a3");
    rd(3'd6, 32'h0, "rxready_cleared");
    rd(3'd7, 32'hA3, "rxdata_empty_repeat");
    rd(3'd6, 32'h0, "rxready_still_0");

    // Overrun keeps the first byte.
    send_rx(8'h11, 1'b1, 8);
    repeat (4) @(negedge clk);
    send_rx(8'h22, 1'b1, 8);
    repeat (4) @(negedge clk);
    rd(3'd6, 32'h1, "rxready_ovr");
    rd(3'd7, 32'h11, "rxdata_ovr");
    rd(3'd6, 32'h0, "rxready_ovr_clr");

    // Framing error stores nothing.
    send_rx(8'h33, 1'b0, 8);
    repeat (4) @(negedge clk);
    rd(3'd6, 32'h0, "rxready_frame_err");
    rd(3'd7, 32'h11, "rxdata_frame_keep");

    // Two-cycle glitch is rejected.
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    rd(3'd6, 32'h0, "rxready_glitch");

    // SOFTRESET mid-frame; DIV must survive it.
    wr(3'd1, 32'd4, "div4_b");
    wr(3'd2, 32'h00, "txdata00");
    repeat (10) @(negedge clk);
    check("tx00_low", {31'b0, txd}, 32'h0);
    wr(3'd0, 32'h1, "softreset");
    check("txd_after_srst", {31'b0, txd}, 32'h1);
    rd(3'd5, 32'h0, "txready_srst");
    wr(3'd3, 32'd1, "txen_again");
    rd(3'd5, 32'h1, "txready_again");
    wr(3'd2, 32'h0F, "txdata0f");
    watch_tx(8'h0F, 4, "tx0f_div_kept");

    // Hardware reset in the middle of a received frame.
    wr(3'd1, 32'd8, "div8_b");
    wr(3'd4, 32'd1, "rxen_again");
    fork
      send_rx(8'h5A, 1'b1, 8);
      begin
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    check("txd_after_rst", {31'b0, txd}, 32'h1);
    rd(3'd6, 32'h0, "rxready_after_rst");
    rd(3'd7, 32'h0, "rxdata_after_rst");
    rd(3'd5, 32'h0, "txready_after_rst");

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
